// File: rtl/lsu_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, LSU FSM states and
// exception codes reported to the core.
package lsu_pkg;

   localparam int NB_WORD   = 32;
   localparam int NB_FUNCT3 = 3;
   localparam int NB_REG    = 5;
   localparam int NB_BE     = NB_WORD / 8;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2
   } lsu_state_t;

   localparam logic [1:0] EXC_LD_MISALIGN = 2'b01;
   localparam logic [1:0] EXC_ST_MISALIGN = 2'b10;
   localparam logic [1:0] EXC_ILLEGAL     = 2'b11;

endpackage

// File: rtl/lsu_if.sv
// Single-port data-memory bus: request/grant on the way out, rvalid/rdata back.
// Signal prefixes are from the LSU's point of view.
interface lsu_if #(
   parameter int NB_WORD = 32,
   parameter int NB_BE   = NB_WORD / 8
) ();
   logic               o_mem_req;
   logic               o_mem_we;
   logic [NB_WORD-1:0] o_mem_addr;
   logic [NB_BE-1:0]   o_mem_be;
   logic [NB_WORD-1:0] o_mem_wdata;
   logic               i_mem_gnt;
   logic               i_mem_rvalid;
   logic [NB_WORD-1:0] i_mem_rdata;

   modport master (
      output o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
      input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
   );

   modport slave (
      input  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
      output i_mem_gnt, i_mem_rvalid, i_mem_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// Purely combinational lane logic: store byte enables / replicated write data,
// load extraction with sign/zero extension, and legality/alignment flags.
module lsu_align #(
   parameter int NB_WORD   = 32,
   parameter int NB_FUNCT3 = 3,
   parameter int NB_BE     = NB_WORD / 8
) (
   input  logic                 i_is_load,
   input  logic                 i_is_store,
   input  logic [NB_FUNCT3-1:0] i_funct3,
   input  logic [1:0]           i_addr_lo,
   input  logic [NB_WORD-1:0]   i_store_data,
   input  logic [NB_WORD-1:0]   i_rdata,
   output logic [NB_BE-1:0]     o_be,
   output logic [NB_WORD-1:0]   o_wdata,
   output logic [NB_WORD-1:0]   o_load_data,
   output logic                 o_misaligned,
   output logic                 o_illegal
);
   import lsu_pkg::*;

   logic [NB_WORD-1:0] w_shifted;
   logic               w_ld_legal;
   logic               w_st_legal;

   assign w_shifted  = i_rdata >> {i_addr_lo, 3'b000};
   assign w_ld_legal = i_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
   assign w_st_legal = i_funct3 inside {F3_SB, F3_SH, F3_SW};

   assign o_illegal = (i_is_load & i_is_store)
                    | (i_is_load & ~w_ld_legal)
                    | (i_is_store & ~w_st_legal);

   assign o_misaligned = ((i_funct3[1:0] == F3_LH[1:0]) && i_addr_lo[0])
                       || ((i_funct3[1:0] == F3_LW[1:0]) && (i_addr_lo != 2'b00));

   always_comb begin
      o_be    = '1;
      o_wdata = i_store_data;
      case (i_funct3[1:0])
         F3_SB[1:0]: begin
            o_be    = {{(NB_BE-1){1'b0}}, 1'b1} << i_addr_lo;
            o_wdata = {NB_BE{i_store_data[7:0]}};
         end
         F3_SH[1:0]: begin
            o_be    = {{(NB_BE-2){1'b0}}, 2'b11} << i_addr_lo;
            o_wdata = {(NB_BE/2){i_store_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      o_load_data = w_shifted;
      case (i_funct3)
         F3_LB:   o_load_data = {{(NB_WORD-8){w_shifted[7]}}, w_shifted[7:0]};
         F3_LH:   o_load_data = {{(NB_WORD-16){w_shifted[15]}}, w_shifted[15:0]};
         F3_LBU:  o_load_data = {{(NB_WORD-8){1'b0}}, w_shifted[7:0]};
         F3_LHU:  o_load_data = {{(NB_WORD-16){1'b0}}, w_shifted[15:0]};
         default: ;
      endcase
   end
endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one memory transaction in flight, accept-time
// legality/alignment checks, registered writeback and exception pulses.
module lsu #(
   parameter int NB_WORD   = 32,
   parameter int NB_FUNCT3 = 3,
   parameter int NB_REG    = 5,
   parameter int NB_BE     = NB_WORD / 8
) (
   input  logic                 i_clock,
   input  logic                 i_reset_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic                 i_is_load,
   input  logic                 i_is_store,
   input  logic [NB_FUNCT3-1:0] i_funct3,
   input  logic [NB_WORD-1:0]   i_addr,
   input  logic [NB_WORD-1:0]   i_store_data,
   input  logic [NB_REG-1:0]    i_rd,
   lsu_if.master                mem_bus,
   output logic                 o_wb_valid,
   output logic [NB_REG-1:0]    o_wb_rd,
   output logic [NB_WORD-1:0]   o_wb_data,
   output logic                 o_exc_valid,
   output logic [1:0]           o_exc_code
);
   import lsu_pkg::*;

   lsu_state_t           r_state;
   logic                 r_mem_req;
   logic                 r_mem_we;
   logic [NB_WORD-1:0]   r_mem_addr;
   logic [NB_BE-1:0]     r_mem_be;
   logic [NB_WORD-1:0]   r_mem_wdata;
   logic [NB_REG-1:0]    r_rd;
   logic [NB_FUNCT3-1:0] r_funct3;
   logic [1:0]           r_addr_lo;
   logic                 r_wb_valid;
   logic [NB_WORD-1:0]   r_wb_data;
   logic                 r_exc_valid;
   logic [1:0]           r_exc_code;

   logic [NB_FUNCT3-1:0] w_sel_funct3;
   logic [1:0]           w_sel_addr_lo;
   logic [NB_BE-1:0]     w_be;
   logic [NB_WORD-1:0]   w_wdata;
   logic [NB_WORD-1:0]   w_load_data;
   logic                 w_misaligned;
   logic                 w_illegal;

   assign o_ready = (r_state == IDLE);

   // While idle the aligner checks the incoming op; once busy it extracts
   // load data using the op captured at accept time.
   assign w_sel_funct3  = (r_state == IDLE) ? i_funct3    : r_funct3;
   assign w_sel_addr_lo = (r_state == IDLE) ? i_addr[1:0] : r_addr_lo;

   lsu_align #(
      .NB_WORD   (NB_WORD),
      .NB_FUNCT3 (NB_FUNCT3),
      .NB_BE     (NB_BE)
   ) u_align (
      .i_is_load    (i_is_load),
      .i_is_store   (i_is_store),
      .i_funct3     (w_sel_funct3),
      .i_addr_lo    (w_sel_addr_lo),
      .i_store_data (i_store_data),
      .i_rdata      (mem_bus.i_mem_rdata),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_load_data  (w_load_data),
      .o_misaligned (w_misaligned),
      .o_illegal    (w_illegal)
   );

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
         r_rd        <= '0;
         r_funct3    <= '0;
         r_addr_lo   <= '0;
         r_wb_valid  <= 1'b0;
         r_wb_data   <= '0;
         r_exc_valid <= 1'b0;
         r_exc_code  <= '0;
      end else begin
         r_wb_valid  <= 1'b0;
         r_exc_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_valid && (i_is_load || i_is_store)) begin
                  if (w_illegal) begin
                     r_exc_valid <= 1'b1;
                     r_exc_code  <= EXC_ILLEGAL;
                  end else if (w_misaligned) begin
                     r_exc_valid <= 1'b1;
                     r_exc_code  <= i_is_load ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
                  end else begin
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= i_is_store;
                     r_mem_addr  <= {i_addr[NB_WORD-1:2], 2'b00};
                     r_mem_be    <= w_be;
                     r_mem_wdata <= w_wdata;
                     r_rd        <= i_rd;
                     r_funct3    <= i_funct3;
                     r_addr_lo   <= i_addr[1:0];
                     r_state     <= REQ;
                  end
               end
            end
            REQ: begin
               if (mem_bus.i_mem_gnt) begin
                  r_mem_req <= 1'b0;
                  r_state   <= r_mem_we ? IDLE : WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               if (mem_bus.i_mem_rvalid) begin
                  r_wb_valid <= 1'b1;
                  r_wb_data  <= w_load_data;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_bus.o_mem_req   = r_mem_req;
   assign mem_bus.o_mem_we    = r_mem_we;
   assign mem_bus.o_mem_addr  = r_mem_addr;
   assign mem_bus.o_mem_be    = r_mem_be;
   assign mem_bus.o_mem_wdata = r_mem_wdata;
   assign o_wb_valid          = r_wb_valid;
   assign o_wb_rd             = r_rd;
   assign o_wb_data           = r_wb_data;
   assign o_exc_valid         = r_exc_valid;
   assign o_exc_code          = r_exc_code;
endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, reset corner sequences, then random
// ops checked against a spec-level model with a simple memory responder.
module tb_lsu;
   import lsu_pkg::*;

   logic        i_clock = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic        i_is_load = 1'b0;
   logic        i_is_store = 1'b0;
   logic [2:0]  i_funct3 = '0;
   logic [31:0] i_addr = '0;
   logic [31:0] i_store_data = '0;
   logic [4:0]  i_rd = '0;
   logic        o_wb_valid;
   logic [4:0]  o_wb_rd;
   logic [31:0] o_wb_data;
   logic        o_exc_valid;
   logic [1:0]  o_exc_code;

   lsu_if #(.NB_WORD(32)) mem_bus ();

   lsu #(.NB_WORD(32), .NB_FUNCT3(3), .NB_REG(5), .NB_BE(4)) dut (
      .i_clock      (i_clock),
      .i_reset_n    (i_reset_n),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_is_load    (i_is_load),
      .i_is_store   (i_is_store),
      .i_funct3     (i_funct3),
      .i_addr       (i_addr),
      .i_store_data (i_store_data),
      .i_rd         (i_rd),
      .mem_bus      (mem_bus),
      .o_wb_valid   (o_wb_valid),
      .o_wb_rd      (o_wb_rd),
      .o_wb_data    (o_wb_data),
      .o_exc_valid  (o_exc_valid),
      .o_exc_code   (o_exc_code)
   );

   always #5 i_clock = ~i_clock;

   typedef struct packed {
      logic        is_load;
      logic        is_store;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] rdata;
      logic [4:0]  rd;
      int          gnt_dly;
      int          rv_dly;
   } op_t;

   typedef struct packed {
      int          ready_acc;
      int          ready_cyc;
      int          req_cycles;
      int          unstable;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
      int          exc_cnt;
      logic [1:0]  exc_code;
      int          wb_cnt;
      logic [31:0] wb_data;
      logic [4:0]  wb_rd;
      int          wb_cyc;
      int          both;
   } obs_t;

   typedef struct packed {
      op_t         op;
      logic        exc;
      logic [1:0]  code;
      logic        req;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        wb;
      logic [31:0] wb_data;
      int          ready_cyc;
      int          wb_cyc;
   } vec_t;

   int n_checks = 0;
   int n_fail = 0;
   bit noise = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic op_t mk_op(input logic l, input logic s, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] rdata, input logic [4:0] rd,
                                 input int gd, input int rvd);
      op_t o;
      o.is_load = l; o.is_store = s; o.f3 = f3; o.addr = addr; o.sdata = sdata;
      o.rdata = rdata; o.rd = rd; o.gnt_dly = gd; o.rv_dly = rvd;
      return o;
   endfunction

   function automatic vec_t mk_vec(input op_t op, input logic exc, input logic [1:0] code,
                                   input logic req, input logic [31:0] addr, input logic [3:0] be,
                                   input logic [31:0] wdata, input logic wb, input logic [31:0] wbd,
                                   input int rdy, input int wbc);
      vec_t v;
      v.op = op; v.exc = exc; v.code = code; v.req = req; v.addr = addr; v.be = be;
      v.wdata = wdata; v.wb = wb; v.wb_data = wbd; v.ready_cyc = rdy; v.wb_cyc = wbc;
      return v;
   endfunction

   // Reference: expected observation from the architectural rules.
   function automatic obs_t model(input op_t op);
      obs_t e;
      int size, g;
      logic [31:0] w, b;
      logic illegal;
      e = '0;
      e.ready_acc = 1;
      e.ready_cyc = 1;
      if (!op.is_load && !op.is_store) return e;
      illegal = (op.is_load && op.is_store)
             || (op.is_load && !(op.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
             || (op.is_store && !(op.f3 inside {3'd0, 3'd1, 3'd2}));
      if (illegal) begin
         e.exc_cnt = 1; e.exc_code = 2'b11; return e;
      end
      size = 1 << op.f3[1:0];
      if ((op.addr % size) != 0) begin
         e.exc_cnt = 1; e.exc_code = op.is_load ? 2'b01 : 2'b10; return e;
      end
      g = 1 + op.gnt_dly;
      e.req_cycles = op.gnt_dly + 1;
      e.addr = op.addr - (op.addr % 4);
      e.we = op.is_store;
      if (op.is_store) begin
         e.be = 4'(((1 << size) - 1) << (op.addr % 4));
         if (size == 1)      e.wdata = (op.sdata & 32'hFF) * 32'h0101_0101;
         else if (size == 2) e.wdata = (op.sdata & 32'hFFFF) * 32'h0001_0001;
         else                e.wdata = op.sdata;
         e.ready_cyc = g + 1;
      end else begin
         w = op.rdata >> (8 * (op.addr % 4));
         case (op.f3)
            3'd0: begin b = w & 32'hFF;   e.wb_data = (b ^ 32'h80) - 32'h80; end
            3'd1: begin b = w & 32'hFFFF; e.wb_data = (b ^ 32'h8000) - 32'h8000; end
            3'd4: e.wb_data = w & 32'hFF;
            3'd5: e.wb_data = w & 32'hFFFF;
            default: e.wb_data = w;
         endcase
         e.wb_cnt = 1; e.wb_rd = op.rd;
         e.wb_cyc = g + op.rv_dly + 1;
         e.ready_cyc = e.wb_cyc;
      end
      return e;
   endfunction

   // Present one op, act as the memory for a bounded number of cycles, record what happened.
   task automatic run_op(input op_t op, output obs_t ob);
      int g, rv_at, n;
      ob = '0;
      g = 0; rv_at = 0;
      @(posedge i_clock); #1;
      ob.ready_acc = int'(o_ready);
      i_valid = 1'b1; i_is_load = op.is_load; i_is_store = op.is_store;
      i_funct3 = op.f3; i_addr = op.addr; i_store_data = op.sdata; i_rd = op.rd;
      @(posedge i_clock); #1;
      i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
      i_addr = $urandom; i_store_data = $urandom; i_funct3 = 3'($urandom_range(0, 7));
      n = op.gnt_dly + op.rv_dly + 6;
      for (int k = 1; k <= n; k++) begin
         if (o_ready && ob.ready_cyc == 0) ob.ready_cyc = k;
         if (mem_bus.o_mem_req) begin
            if (ob.req_cycles == 0) begin
               ob.addr = mem_bus.o_mem_addr; ob.be = mem_bus.o_mem_be;
               ob.wdata = mem_bus.o_mem_wdata; ob.we = mem_bus.o_mem_we;
            end else if (ob.addr !== mem_bus.o_mem_addr || ob.be !== mem_bus.o_mem_be ||
                         ob.wdata !== mem_bus.o_mem_wdata || ob.we !== mem_bus.o_mem_we) begin
               ob.unstable = 1;
            end
            ob.req_cycles++;
         end
         if (o_exc_valid) begin ob.exc_cnt++; ob.exc_code = o_exc_code; end
         if (o_wb_valid) begin
            ob.wb_cnt++; ob.wb_data = o_wb_data; ob.wb_rd = o_wb_rd; ob.wb_cyc = k;
         end
         if (o_exc_valid && o_wb_valid) ob.both++;
         mem_bus.i_mem_gnt = 1'b0;
         mem_bus.i_mem_rvalid = 1'b0;
         mem_bus.i_mem_rdata = $urandom;
         if (mem_bus.o_mem_req) begin
            if (g == 0 && ob.req_cycles == op.gnt_dly + 1) begin
               mem_bus.i_mem_gnt = 1'b1; g = k; rv_at = k + op.rv_dly;
            end else if (noise) begin
               mem_bus.i_mem_rvalid = 1'($urandom_range(0, 1));
            end
         end else if (g != 0 && op.is_load && k == rv_at) begin
            mem_bus.i_mem_rvalid = 1'b1; mem_bus.i_mem_rdata = op.rdata;
         end else if (noise) begin
            mem_bus.i_mem_gnt = 1'($urandom_range(0, 1));
            if (g == 0 || k > rv_at || !op.is_load)
               mem_bus.i_mem_rvalid = 1'($urandom_range(0, 1));
         end
         @(posedge i_clock); #1;
      end
      mem_bus.i_mem_gnt = 1'b0;
      mem_bus.i_mem_rvalid = 1'b0;
   endtask

   task automatic compare(input string tag, input op_t op, input obs_t ob, input obs_t ex);
      chk({tag, ".ready_at_accept"}, ob.ready_acc, ex.ready_acc);
      chk({tag, ".exc_pulses"}, ob.exc_cnt, ex.exc_cnt);
      if (ex.exc_cnt != 0) chk({tag, ".exc_code"}, 32'(ob.exc_code), 32'(ex.exc_code));
      chk({tag, ".req_cycles"}, ob.req_cycles, ex.req_cycles);
      if (ex.req_cycles != 0) begin
         chk({tag, ".mem_addr"}, ob.addr, ex.addr);
         chk({tag, ".mem_we"}, 32'(ob.we), 32'(ex.we));
         chk({tag, ".req_stable"}, ob.unstable, 0);
         if (op.is_store) begin
            chk({tag, ".mem_be"}, 32'(ob.be), 32'(ex.be));
            chk({tag, ".mem_wdata"}, ob.wdata, ex.wdata);
         end
      end
      chk({tag, ".wb_pulses"}, ob.wb_cnt, ex.wb_cnt);
      if (ex.wb_cnt != 0) begin
         chk({tag, ".wb_data"}, ob.wb_data, ex.wb_data);
         chk({tag, ".wb_rd"}, 32'(ob.wb_rd), 32'(ex.wb_rd));
         chk({tag, ".wb_cycle"}, ob.wb_cyc, ex.wb_cyc);
      end
      chk({tag, ".ready_cycle"}, ob.ready_cyc, ex.ready_cyc);
      chk({tag, ".wb_exc_overlap"}, ob.both, 0);
      $display("%s: ld=%0d st=%0d f3=%03b addr=0x%08h -> req=%0d exc=%0d/%0d wb=%0d data=0x%08h rd=%0d",
               tag, op.is_load, op.is_store, op.f3, op.addr, ob.req_cycles, ob.exc_cnt,
               ob.exc_code, ob.wb_cnt, ob.wb_data, ob.wb_rd);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t  tbl[15];
      op_t   op;
      obs_t  ob, ex;
      int    cnt_wb, cnt_req, cnt_exc, r;
      logic [2:0] ld_f3[5];
      logic [2:0] st_f3[3];

      ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      st_f3 = '{3'd0, 3'd1, 3'd2};

      tbl[0]  = mk_vec(mk_op(0,1,3'b000,32'h1003,32'hAABBCCDD,32'h0,5'd3,0,1), 0,2'b00,1,32'h1000,4'b1000,32'hDDDDDDDD,0,32'h0,2,0);
      tbl[1]  = mk_vec(mk_op(1,0,3'b000,32'h2001,32'h0,32'h123480FF,5'd7,0,1),  0,2'b00,1,32'h2000,4'h0,32'h0,1,32'hFFFFFF80,3,3);
      tbl[2]  = mk_vec(mk_op(1,0,3'b100,32'h2001,32'h0,32'h123480FF,5'd9,0,1),  0,2'b00,1,32'h2000,4'h0,32'h0,1,32'h00000080,3,3);
      tbl[3]  = mk_vec(mk_op(1,0,3'b001,32'h2002,32'h0,32'h80010000,5'd10,0,1), 0,2'b00,1,32'h2000,4'h0,32'h0,1,32'hFFFF8001,3,3);
      tbl[4]  = mk_vec(mk_op(1,0,3'b010,32'h2002,32'h0,32'h0,5'd11,0,1),        1,2'b01,0,32'h0,4'h0,32'h0,0,32'h0,1,0);
      tbl[5]  = mk_vec(mk_op(0,1,3'b010,32'h40,32'hCAFEF00D,32'h0,5'd2,3,1),    0,2'b00,1,32'h40,4'b1111,32'hCAFEF00D,0,32'h0,5,0);
      tbl[6]  = mk_vec(mk_op(1,0,3'b010,32'h44,32'h0,32'h13579BDF,5'd12,0,2),   0,2'b00,1,32'h44,4'h0,32'h0,1,32'h13579BDF,4,4);
      tbl[7]  = mk_vec(mk_op(1,0,3'b011,32'h50,32'h0,32'h0,5'd4,0,1),           1,2'b11,0,32'h0,4'h0,32'h0,0,32'h0,1,0);
      tbl[8]  = mk_vec(mk_op(1,1,3'b010,32'h50,32'h0,32'h0,5'd4,0,1),           1,2'b11,0,32'h0,4'h0,32'h0,0,32'h0,1,0);
      tbl[9]  = mk_vec(mk_op(0,1,3'b100,32'h50,32'h0,32'h0,5'd4,0,1),           1,2'b11,0,32'h0,4'h0,32'h0,0,32'h0,1,0);
      tbl[10] = mk_vec(mk_op(0,1,3'b001,32'h1002,32'h1234ABCD,32'h0,5'd5,1,1),  0,2'b00,1,32'h1000,4'b1100,32'hABCDABCD,0,32'h0,3,0);
      tbl[11] = mk_vec(mk_op(0,0,3'b010,32'h60,32'h0,32'h0,5'd6,0,1),           0,2'b00,0,32'h0,4'h0,32'h0,0,32'h0,1,0);
      tbl[12] = mk_vec(mk_op(0,1,3'b001,32'h1001,32'h0,32'h0,5'd6,0,1),         1,2'b10,0,32'h0,4'h0,32'h0,0,32'h0,1,0);
      tbl[13] = mk_vec(mk_op(1,0,3'b101,32'h3000,32'h0,32'h0000F00F,5'd31,2,3), 0,2'b00,1,32'h3000,4'h0,32'h0,1,32'h0000F00F,7,7);
      tbl[14] = mk_vec(mk_op(1,0,3'b001,32'h3002,32'h0,32'hF00F1234,5'd1,0,1),  0,2'b00,1,32'h3000,4'h0,32'h0,1,32'hFFFFF00F,3,3);

      mem_bus.i_mem_gnt = 1'b0;
      mem_bus.i_mem_rvalid = 1'b0;
      mem_bus.i_mem_rdata = '0;

      #3;
      chk("reset.ready", 32'(o_ready), 1);
      chk("reset.mem_req", 32'(mem_bus.o_mem_req), 0);
      chk("reset.mem_we", 32'(mem_bus.o_mem_we), 0);
      chk("reset.mem_addr", mem_bus.o_mem_addr, 0);
      chk("reset.mem_be", 32'(mem_bus.o_mem_be), 0);
      chk("reset.mem_wdata", mem_bus.o_mem_wdata, 0);
      chk("reset.wb_valid", 32'(o_wb_valid), 0);
      chk("reset.wb_data", o_wb_data, 0);
      chk("reset.wb_rd", 32'(o_wb_rd), 0);
      chk("reset.exc_valid", 32'(o_exc_valid), 0);
      chk("reset.exc_code", 32'(o_exc_code), 0);
      $display("reset: ready=%0d req=%0d", o_ready, mem_bus.o_mem_req);
      #9 i_reset_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         ex = '0;
         ex.ready_acc = 1;
         ex.exc_cnt = int'(tbl[i].exc);
         ex.exc_code = tbl[i].code;
         ex.req_cycles = tbl[i].req ? tbl[i].op.gnt_dly + 1 : 0;
         ex.addr = tbl[i].addr;
         ex.be = tbl[i].be;
         ex.wdata = tbl[i].wdata;
         ex.we = tbl[i].op.is_store;
         ex.wb_cnt = int'(tbl[i].wb);
         ex.wb_data = tbl[i].wb_data;
         ex.wb_rd = tbl[i].op.rd;
         ex.wb_cyc = tbl[i].wb_cyc;
         ex.ready_cyc = tbl[i].ready_cyc;
         run_op(tbl[i].op, ob);
         compare($sformatf("vec%0d", i), tbl[i].op, ob, ex);
      end

      // Reset while a store waits for grant: request must drop without a clock edge.
      @(posedge i_clock); #1;
      i_valid = 1'b1; i_is_store = 1'b1; i_funct3 = 3'b010; i_addr = 32'h80; i_store_data = 32'h55AA55AA;
      @(posedge i_clock); #1;
      i_valid = 1'b0; i_is_store = 1'b0;
      chk("rst_req.req_before", 32'(mem_bus.o_mem_req), 1);
      #2 i_reset_n = 1'b0;
      #1;
      chk("rst_req.req", 32'(mem_bus.o_mem_req), 0);
      chk("rst_req.ready", 32'(o_ready), 1);
      chk("rst_req.addr", mem_bus.o_mem_addr, 0);
      chk("rst_req.be", 32'(mem_bus.o_mem_be), 0);
      chk("rst_req.wdata", mem_bus.o_mem_wdata, 0);
      $display("rst_req: req=%0d ready=%0d", mem_bus.o_mem_req, o_ready);
      #2 i_reset_n = 1'b1;

      // Reset while a load waits for its response, then a stale response arrives.
      @(posedge i_clock); #1;
      i_valid = 1'b1; i_is_load = 1'b1; i_funct3 = 3'b010; i_addr = 32'h84; i_rd = 5'd5;
      @(posedge i_clock); #1;
      i_valid = 1'b0; i_is_load = 1'b0;
      mem_bus.i_mem_gnt = 1'b1;
      @(posedge i_clock); #1;
      mem_bus.i_mem_gnt = 1'b0;
      chk("rst_rsp.req_after_gnt", 32'(mem_bus.o_mem_req), 0);
      chk("rst_rsp.ready_waiting", 32'(o_ready), 0);
      #2 i_reset_n = 1'b0;
      #1;
      chk("rst_rsp.ready", 32'(o_ready), 1);
      chk("rst_rsp.req", 32'(mem_bus.o_mem_req), 0);
      #2 i_reset_n = 1'b1;
      mem_bus.i_mem_rvalid = 1'b1; mem_bus.i_mem_rdata = 32'hDEADBEEF; mem_bus.i_mem_gnt = 1'b1;
      cnt_wb = 0; cnt_req = 0; cnt_exc = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge i_clock); #1;
         cnt_wb += int'(o_wb_valid);
         cnt_req += int'(mem_bus.o_mem_req);
         cnt_exc += int'(o_exc_valid);
      end
      mem_bus.i_mem_rvalid = 1'b0; mem_bus.i_mem_gnt = 1'b0;
      chk("stray_rsp.wb_pulses", cnt_wb, 0);
      chk("stray_rsp.req_cycles", cnt_req, 0);
      chk("stray_rsp.exc_pulses", cnt_exc, 0);
      chk("stray_rsp.ready", 32'(o_ready), 1);
      $display("stray_rsp: wb=%0d req=%0d exc=%0d", cnt_wb, cnt_req, cnt_exc);

      noise = 1'b1;
      for (int i = 0; i < 200; i++) begin
         r = $urandom_range(0, 19);
         op.is_load  = (r >= 2 && r <= 10) || r == 1;
         op.is_store = (r > 10) || r == 1;
         if ($urandom_range(0, 99) < 15)  op.f3 = 3'($urandom_range(0, 7));
         else if (op.is_store && !op.is_load) op.f3 = st_f3[$urandom_range(0, 2)];
         else                                  op.f3 = ld_f3[$urandom_range(0, 4)];
         op.addr = $urandom;
         if ($urandom_range(0, 99) < 70)
            op.addr = op.addr & ~((32'd1 << op.f3[1:0]) - 32'd1);
         op.sdata = $urandom;
         op.rdata = $urandom;
         op.rd = 5'($urandom_range(0, 31));
         op.gnt_dly = $urandom_range(0, 3);
         op.rv_dly = $urandom_range(1, 3);
         run_op(op, ob);
         compare($sformatf("rnd%0d", i), op, ob, model(op));
      end
      noise = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
